next_pc_unit: RTL and testbench
===============================

Name: next_pc_unit

Overview:
- Next-address stage directly upstream of the program counter register.
- Each cycle it takes the current 10-bit instruction address plus decoded control-flow signals and produces the next address and the PC write enable.
- Handles branch, jump, call and return through an internal return-address stack, plus halt and wait-for-input stalls.
- NextPc drives the PC's modified-address input; PcWrite drives the PC's write-function input.

Parameters:
- ADDR_W, 10, instruction address width.
- STACK_DEPTH, 8, return-address stack entries (power of two, ≥2).
- SP_W, 4, stack depth counter width; must hold 0..STACK_DEPTH.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- PcAtual  input  ADDR_W  current instruction address from the PC register.
- CtlBranch  input  1  conditional branch instruction decoded.
- CondTrue  input  1  branch condition result from the ALU.
- CtlJump  input  1  unconditional jump to an immediate target.
- CtlJal  input  1  call: push return address, jump to an immediate target.
- CtlRet  input  1  return: pop the stack and jump to the popped address.
- CtlJr  input  1  jump to a register value.
- CtlHalt  input  1  halt instruction.
- CtlIn  input  1  input instruction; stalls until the user confirms.
- InConfirm  input  1  single-cycle, debounced confirm pulse.
- TargetImm  input  ADDR_W  immediate target address.
- TargetReg  input  ADDR_W  register target address.
- NextPc  output  ADDR_W  next instruction address.
- PcWrite  output  1  PC load enable.
- Halted  output  1  high while in HALT.
- Waiting  output  1  high while in WAIT_IN.
- StackDepth  output  SP_W  number of valid stack entries.
- StackOverflow  output  1  sticky overflow flag.
- StackUnderflow  output  1  sticky underflow flag.

Behaviour:
- FSM states: BOOT, RUN, WAIT_IN, HALT.
- Reset (checked at the clock edge, overrides everything):
  - state = BOOT; stack pointer = 0; both sticky flags = 0.
  - Stack contents are don't-care.
- Outputs after reset: PcWrite = 0, NextPc = 0, Halted = 0, Waiting = 0, StackDepth = 0.
- BOOT lasts exactly one cycle:
  - PcWrite = 0, NextPc = 0, all Ctl* ignored.
  - Next state is RUN.
- RUN: NextPc and PcWrite are combinational from the inputs (zero latency). The PC loads NextPc on the same edge. Priority, highest first:
  1. CtlHalt: PcWrite = 0; go to HALT.
  2. CtlIn: PcWrite = 0; go to WAIT_IN. InConfirm is ignored in RUN, so there is always at least one wait cycle.
  3. CtlRet:
     - Stack not empty: NextPc = top entry; pop at the edge.
     - Stack empty: NextPc = 0; set StackUnderflow; stack pointer unchanged.
  4. CtlJal:
     - NextPc = TargetImm; push (PcAtual+1) mod 2^ADDR_W at the edge.
     - If the stack is full, the push wraps circularly, overwriting the oldest entry. StackDepth stays at STACK_DEPTH and StackOverflow is set.
  5. CtlJr: NextPc = TargetReg.
  6. CtlJump: NextPc = TargetImm.
  7. CtlBranch with CondTrue = 1: NextPc = TargetImm.
  8. Otherwise: NextPc = (PcAtual+1) mod 2^ADDR_W. Address 1023 wraps to 0.
  - PcWrite = 1 for cases 3–8.
- WAIT_IN:
  - PcWrite = 0 and NextPc = PcAtual until InConfirm = 1.
  - On the cycle InConfirm = 1: NextPc = PcAtual+1 (wrapping), PcWrite = 1, next state RUN.
  - Ctl* inputs are ignored in this state.
- HALT: PcWrite = 0, NextPc = PcAtual. Only Reset exits this state.
- Only one push or pop happens per cycle. No stack activity occurs in BOOT, WAIT_IN or HALT, or while PcWrite = 0.
- Sticky flags clear only on Reset.
- Reset asserted mid-WAIT_IN or mid-HALT returns to BOOT on that edge; no pending push or pop is applied.

Test Plan:
- Reset pulse, then plain sequencing:
  - Cycle after reset: PcWrite = 0.
  - Then, with PcAtual = 5 and no Ctl: NextPc = 6, PcWrite = 1.
  - With PcAtual = 1023: NextPc = 0.
- Priority: with CtlBranch = 1, CondTrue = 1, CtlJump = 1, CtlJr = 1, TargetImm = 40 and TargetReg = 77, NextPc = 77. With only CtlBranch = 1 and CondTrue = 0, NextPc = PcAtual+1.
- Call/return:
  - CtlJal at PcAtual = 10 with TargetImm = 100 → NextPc = 100, StackDepth = 1.
  - Then CtlRet → NextPc = 11, StackDepth = 0.
  - Nested calls at PC = 20 and 30 return 31, then 21.
- Overflow and underflow:
  - 9 consecutive CtlJal → StackOverflow = 1, StackDepth = 8. Eight CtlRet then return the last 8 return addresses, newest first.
  - A further CtlRet → NextPc = 0, StackUnderflow = 1.
- Input wait:
  - CtlIn at PcAtual = 50 with InConfirm already high → PcWrite = 0, Waiting = 1.
  - Hold 4 cycles, then pulse InConfirm → NextPc = 51, PcWrite = 1 on that cycle, Waiting = 0 next cycle.
- Halt and reset mid-operation:
  - CtlHalt → Halted = 1, PcWrite stays 0 for 10 cycles with Ctl* toggling.
  - Reset → BOOT, flags and StackDepth return to 0, then normal sequencing resumes.

Source files
------------

// File: rtl/next_pc_unit.sv
// Next-address stage feeding the PC register: sequencing, branches, jumps,
// call/return through a circular return-address stack, and halt/input stalls.
module next_pc_unit #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 8,
  parameter int SP_W        = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PcAtual,
  input  logic              CtlBranch,
  input  logic              CondTrue,
  input  logic              CtlJump,
  input  logic              CtlJal,
  input  logic              CtlRet,
  input  logic              CtlJr,
  input  logic              CtlHalt,
  input  logic              CtlIn,
  input  logic              InConfirm,
  input  logic [ADDR_W-1:0] TargetImm,
  input  logic [ADDR_W-1:0] TargetReg,
  output logic [ADDR_W-1:0] NextPc,
  output logic              PcWrite,
  output logic              Halted,
  output logic              Waiting,
  output logic [SP_W-1:0]   StackDepth,
  output logic              StackOverflow,
  output logic              StackUnderflow
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, WAIT_IN, HALT} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [SP_W-1:0]   depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];

  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] top;
  logic              pc_write;
  logic              push;
  logic              pop;
  logic              stack_empty;
  logic              stack_full;

  assign pc_inc      = PcAtual + ADDR_W'(1);
  assign top         = mem_q[wp_q - PTR_W'(1)];
  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == SP_W'(STACK_DEPTH));

  always_comb begin
    state_d  = state_q;
    next_pc  = '0;
    pc_write = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    wp_d     = wp_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (CtlHalt) begin
          next_pc = PcAtual;
          state_d = HALT;
        end else if (CtlIn) begin
          next_pc = PcAtual;
          state_d = WAIT_IN;
        end else begin
          pc_write = 1'b1;
          if (CtlRet) begin
            if (!stack_empty) begin
              next_pc = top;
              pop     = 1'b1;
            end else begin
              next_pc = '0;
              unf_d   = 1'b1;
            end
          end else if (CtlJal) begin
            next_pc = TargetImm;
            push    = 1'b1;
          end else if (CtlJr) begin
            next_pc = TargetReg;
          end else if (CtlJump || (CtlBranch && CondTrue)) begin
            next_pc = TargetImm;
          end else begin
            next_pc = pc_inc;
          end
        end
      end
      WAIT_IN: begin
        if (InConfirm) begin
          next_pc  = pc_inc;
          pc_write = 1'b1;
          state_d  = RUN;
        end else begin
          next_pc = PcAtual;
        end
      end
      HALT:    next_pc = PcAtual;
      default: state_d = BOOT;
    endcase

    // A push onto a full stack overwrites the oldest entry; depth saturates.
    if (push) begin
      wp_d = wp_q + PTR_W'(1);
      if (stack_full) ovf_d = 1'b1;
      else            depth_d = depth_q + SP_W'(1);
    end else if (pop) begin
      wp_d    = wp_q - PTR_W'(1);
      depth_d = depth_q - SP_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= BOOT;
      wp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset && push) mem_q[wp_q] <= pc_inc;
  end

  assign NextPc         = next_pc;
  assign PcWrite        = pc_write;
  assign Halted         = (state_q == HALT);
  assign Waiting        = (state_q == WAIT_IN);
  assign StackDepth     = depth_q;
  assign StackOverflow  = ovf_q;
  assign StackUnderflow = unf_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares every output.
module tb_next_pc_unit;

  localparam logic [7:0] C_HALT = 8'h80;
  localparam logic [7:0] C_IN   = 8'h40;
  localparam logic [7:0] C_RET  = 8'h20;
  localparam logic [7:0] C_JAL  = 8'h10;
  localparam logic [7:0] C_JR   = 8'h08;
  localparam logic [7:0] C_JUMP = 8'h04;
  localparam logic [7:0] C_BR   = 8'h02;
  localparam logic [7:0] C_COND = 8'h01;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pc_atual = '0;
  logic [7:0] ctl = '0;
  logic       in_confirm = 1'b0;
  logic [9:0] target_imm = '0;
  logic [9:0] target_reg = '0;
  logic [9:0] next_pc;
  logic       pc_write, halted, waiting, ovf, unf;
  logic [3:0] depth;

  typedef struct {
    int         id;
    logic       chk_pc;
    logic [9:0] npc;
    logic       pw, h, w;
    logic [3:0] d;
    logic       o, u;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec = 0;

  always #5 clk = ~clk;

  next_pc_unit dut (
    .Clock(clk), .Reset(reset), .PcAtual(pc_atual),
    .CtlBranch(ctl[1]), .CondTrue(ctl[0]), .CtlJump(ctl[2]),
    .CtlJal(ctl[4]), .CtlRet(ctl[5]), .CtlJr(ctl[3]),
    .CtlHalt(ctl[7]), .CtlIn(ctl[6]), .InConfirm(in_confirm),
    .TargetImm(target_imm), .TargetReg(target_reg),
    .NextPc(next_pc), .PcWrite(pc_write), .Halted(halted), .Waiting(waiting),
    .StackDepth(depth), .StackOverflow(ovf), .StackUnderflow(unf)
  );

  function automatic exp_t mk(input logic cpc, input logic [9:0] npc,
                              input logic pw, input logic h, input logic w,
                              input logic [3:0] d, input logic o, input logic u);
    exp_t e;
    e.id = 0; e.chk_pc = cpc; e.npc = npc; e.pw = pw; e.h = h; e.w = w;
    e.d = d; e.o = o; e.u = u;
    return e;
  endfunction

  task automatic checkOutput(input int id, input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL v%0d.%s: got %0d, expected %0d", id, name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] pc, input logic [7:0] c, input logic cfm,
                               input logic [9:0] timm, input logic [9:0] treg, input exp_t e);
    exp_t x;
    @(posedge clk); #1;
    reset = 1'b0; pc_atual = pc; ctl = c; in_confirm = cfm;
    target_imm = timm; target_reg = treg;
    x = e; x.id = vec++;
    sb.push_back(x);
  endtask

  task automatic resetCycle();
    @(posedge clk); #1;
    reset = 1'b1; ctl = '0; in_confirm = 1'b0;
  endtask

  // Outputs are compared mid-cycle, well away from the edge that consumed them.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_pc) checkOutput(e.id, "NextPc", int'(next_pc), int'(e.npc));
        checkOutput(e.id, "PcWrite", int'(pc_write), int'(e.pw));
        checkOutput(e.id, "Halted", int'(halted), int'(e.h));
        checkOutput(e.id, "Waiting", int'(waiting), int'(e.w));
        checkOutput(e.id, "StackDepth", int'(depth), int'(e.d));
        checkOutput(e.id, "Overflow", int'(ovf), int'(e.o));
        checkOutput(e.id, "Underflow", int'(unf), int'(e.u));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    resetCycle();
    resetCycle();
    // boot cycle, then plain sequencing and wrap
    applyStimulus(10'd5,    8'h00, 1'b0, 10'd0, 10'd0, mk(1, 10'd0, 0, 0, 0, 4'd0, 0, 0));
    applyStimulus(10'd5,    8'h00, 1'b0, 10'd0, 10'd0, mk(1, 10'd6, 1, 0, 0, 4'd0, 0, 0));
    applyStimulus(10'd1023, 8'h00, 1'b0, 10'd0, 10'd0, mk(1, 10'd0, 1, 0, 0, 4'd0, 0, 0));
    // priority: Jr beats Jump and Branch; untaken branch falls through
    applyStimulus(10'd7, C_BR | C_COND | C_JUMP | C_JR, 1'b0, 10'd40, 10'd77,
                  mk(1, 10'd77, 1, 0, 0, 4'd0, 0, 0));
    applyStimulus(10'd7, C_BR, 1'b0, 10'd40, 10'd77, mk(1, 10'd8, 1, 0, 0, 4'd0, 0, 0));
    applyStimulus(10'd7, C_JUMP, 1'b0, 10'd40, 10'd77, mk(1, 10'd40, 1, 0, 0, 4'd0, 0, 0));
    // call / return
    applyStimulus(10'd10,  C_JAL, 1'b0, 10'd100, 10'd0, mk(1, 10'd100, 1, 0, 0, 4'd0, 0, 0));
    applyStimulus(10'd100, C_RET, 1'b0, 10'd0,   10'd0, mk(1, 10'd11,  1, 0, 0, 4'd1, 0, 0));
    applyStimulus(10'd11,  8'h00, 1'b0, 10'd0,   10'd0, mk(1, 10'd12,  1, 0, 0, 4'd0, 0, 0));
    // nested calls
    applyStimulus(10'd20,  C_JAL, 1'b0, 10'd200, 10'd0, mk(1, 10'd200, 1, 0, 0, 4'd0, 0, 0));
    applyStimulus(10'd30,  C_JAL, 1'b0, 10'd300, 10'd0, mk(1, 10'd300, 1, 0, 0, 4'd1, 0, 0));
    applyStimulus(10'd300, C_RET, 1'b0, 10'd0,   10'd0, mk(1, 10'd31,  1, 0, 0, 4'd2, 0, 0));
    applyStimulus(10'd31,  C_RET, 1'b0, 10'd0,   10'd0, mk(1, 10'd21,  1, 0, 0, 4'd1, 0, 0));
    applyStimulus(10'd21,  8'h00, 1'b0, 10'd0,   10'd0, mk(1, 10'd22,  1, 0, 0, 4'd0, 0, 0));
    // nine calls from 100..108 push 101..109; the oldest (101) is overwritten
    for (int i = 0; i < 9; i++)
      applyStimulus(10'(100 + i), C_JAL, 1'b0, 10'd500, 10'd0,
                    mk(1, 10'd500, 1, 0, 0, (i < 8) ? 4'(i) : 4'd8, 0, 0));
    for (int j = 0; j < 8; j++)
      applyStimulus(10'd600, C_RET, 1'b0, 10'd0, 10'd0,
                    mk(1, 10'(109 - j), 1, 0, 0, 4'(8 - j), 1, 0));
    applyStimulus(10'd600, C_RET, 1'b0, 10'd0, 10'd0, mk(1, 10'd0,  1, 0, 0, 4'd0, 1, 0));
    applyStimulus(10'd40,  8'h00, 1'b0, 10'd0, 10'd0, mk(1, 10'd41, 1, 0, 0, 4'd0, 1, 1));
    // input wait: confirm already high on entry is ignored, controls ignored while waiting
    applyStimulus(10'd50, C_IN, 1'b1, 10'd0, 10'd0, mk(0, 10'd0, 0, 0, 0, 4'd0, 1, 1));
    for (int i = 0; i < 4; i++)
      applyStimulus(10'd50, (i % 2 == 0) ? C_JAL : C_JUMP, 1'b0, 10'd9, 10'd0,
                    mk(1, 10'd50, 0, 0, 1, 4'd0, 1, 1));
    applyStimulus(10'd50, C_JAL, 1'b1, 10'd9, 10'd0, mk(1, 10'd51, 1, 0, 1, 4'd0, 1, 1));
    applyStimulus(10'd51, 8'h00, 1'b0, 10'd0, 10'd0, mk(1, 10'd52, 1, 0, 0, 4'd0, 1, 1));
    // halt holds through toggling controls until reset
    applyStimulus(10'd52, C_HALT, 1'b0, 10'd0, 10'd0, mk(0, 10'd0, 0, 0, 0, 4'd0, 1, 1));
    for (int i = 0; i < 10; i++)
      applyStimulus(10'd52, (i % 2 == 1) ? (C_JAL | C_IN) : (C_RET | C_JUMP), 1'(i % 2),
                    10'd3, 10'd4, mk(1, 10'd52, 0, 1, 0, 4'd0, 1, 1));
    resetCycle();
    applyStimulus(10'd60, C_JAL, 1'b0, 10'd5, 10'd0, mk(1, 10'd0,  0, 0, 0, 4'd0, 0, 0));
    applyStimulus(10'd60, 8'h00, 1'b0, 10'd0, 10'd0, mk(1, 10'd61, 1, 0, 0, 4'd0, 0, 0));
    applyStimulus(10'd61, C_JAL, 1'b0, 10'd5, 10'd0, mk(1, 10'd5,  1, 0, 0, 4'd0, 0, 0));
    applyStimulus(10'd5,  C_RET, 1'b0, 10'd0, 10'd0, mk(1, 10'd62, 1, 0, 0, 4'd1, 0, 0));
    @(posedge clk); #1;
    ctl = '0;
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
